// File: rtl/cpu_pkg.sv
// Shared widths and architectural constants for the execute-side pipeline.
// Imported by operand_stage and operand_forward_mux.
package cpu_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int CTRL_W   = 16;
  localparam int XZR_ADDR = 31;

endpackage

// File: rtl/operand_forward_mux.sv
// Per-source operand resolution: XZR, EX/MEM and MEM/WB forwarding.
// Optional OPERAND_STAGE_PERF_EN exposes a forwarded flag for counting.
module operand_forward_mux
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] addr,
  input  logic          use_src,
  input  logic [DW-1:0] bank_data,
  input  logic [AW-1:0] ex_dest,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [DW-1:0] ex_result,
  input  logic [AW-1:0] wb_dest,
  input  logic          wb_write,
  input  logic [DW-1:0] wb_data,
`ifdef OPERAND_STAGE_PERF_EN
  output logic          forwarded,
`endif
  output logic [DW-1:0] operand,
  output logic          load_hazard
);

  localparam logic [AW-1:0] XZR = AW'(XZR_ADDR);

  logic is_zero;
  logic ex_hit;
  logic wb_hit;
  logic sel_ex;
  logic sel_wb;

  assign is_zero = (addr == XZR);
  assign ex_hit  = use_src && !is_zero
                && (ex_dest == addr) && ex_reg_write;
  assign wb_hit  = use_src && !is_zero
                && (wb_dest == addr) && wb_write;

  // A load in EX/MEM has no data yet; fall through and flag it.
  assign sel_ex = ex_hit && !ex_mem_read;
  assign sel_wb = wb_hit && !sel_ex;

  assign load_hazard = ex_hit && ex_mem_read;

`ifdef OPERAND_STAGE_PERF_EN
  assign forwarded = sel_ex || sel_wb;
`endif

  always_comb begin
    operand = bank_data;
    unique case (1'b1)
      is_zero: operand = '0;
      sel_ex:  operand = ex_result;
      sel_wb:  operand = wb_data;
      default: operand = bank_data;
    endcase
  end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand resolution, RAW hazard stall and pipeline register.
// OPERAND_STAGE_PERF_EN adds stall_count / forward_count outputs.
module operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_address_1,
  input  logic [ADDR_W-1:0] in_address_2,
  input  logic              in_use_1,
  input  logic              in_use_2,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] bank_data_1,
  input  logic [DATA_W-1:0] bank_data_2,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic              wb_write,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
`ifdef OPERAND_STAGE_PERF_EN
  output logic [31:0]       stall_count,
  output logic [31:0]       forward_count,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_operand_1,
  output logic [DATA_W-1:0] out_operand_2,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic [CTRL_W-1:0] out_ctrl
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_ADDR);

  typedef struct packed {
    logic [DATA_W-1:0] operand_1;
    logic [DATA_W-1:0] operand_2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  id_ex_t            id_ex_q;
  id_ex_t            id_ex_d;
  logic              valid_q;
  logic [DATA_W-1:0] opnd_1;
  logic [DATA_W-1:0] opnd_2;
  logic              load_haz_1;
  logic              load_haz_2;
  logic              held_haz_1;
  logic              held_haz_2;
  logic              hazard;
  logic              advance;
  logic              accept;

`ifdef OPERAND_STAGE_PERF_EN
  logic fwd_1;
  logic fwd_2;
`endif

  operand_forward_mux #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_fwd_1 (
    .addr         (in_address_1),
    .use_src      (in_use_1),
    .bank_data    (bank_data_1),
    .ex_dest      (ex_dest),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_result    (ex_result),
    .wb_dest      (wb_dest),
    .wb_write     (wb_write),
    .wb_data      (wb_data),
`ifdef OPERAND_STAGE_PERF_EN
    .forwarded    (fwd_1),
`endif
    .operand      (opnd_1),
    .load_hazard  (load_haz_1)
  );

  operand_forward_mux #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_fwd_2 (
    .addr         (in_address_2),
    .use_src      (in_use_2),
    .bank_data    (bank_data_2),
    .ex_dest      (ex_dest),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_result    (ex_result),
    .wb_dest      (wb_dest),
    .wb_write     (wb_write),
    .wb_data      (wb_data),
`ifdef OPERAND_STAGE_PERF_EN
    .forwarded    (fwd_2),
`endif
    .operand      (opnd_2),
    .load_hazard  (load_haz_2)
  );

  // The held instruction's result is not computed yet: bubble.
  assign held_haz_1 = in_use_1 && (in_address_1 != XZR)
                   && (id_ex_q.dest == in_address_1)
                   && valid_q && id_ex_q.reg_write;
  assign held_haz_2 = in_use_2 && (in_address_2 != XZR)
                   && (id_ex_q.dest == in_address_2)
                   && valid_q && id_ex_q.reg_write;

  assign hazard   = held_haz_1 || held_haz_2
                 || load_haz_1 || load_haz_2;
  assign advance  = !valid_q || out_ready;
  assign in_ready = advance && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    id_ex_d           = id_ex_q;
    id_ex_d.operand_1 = opnd_1;
    id_ex_d.operand_2 = opnd_2;
    id_ex_d.imm       = in_imm;
    id_ex_d.dest      = in_dest;
    id_ex_d.reg_write = in_reg_write;
    id_ex_d.mem_read  = in_mem_read;
    id_ex_d.ctrl      = in_ctrl;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      id_ex_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q <= accept;
      if (accept) id_ex_q <= id_ex_d;
    end
  end

`ifdef OPERAND_STAGE_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_count   <= '0;
      forward_count <= '0;
    end else begin
      if (in_valid && hazard && !flush)
        stall_count <= stall_count + 32'd1;
      if (accept)
        forward_count <= forward_count
                       + 32'(fwd_1) + 32'(fwd_2);
    end
  end
`endif

  assign out_valid     = valid_q;
  assign out_operand_1 = id_ex_q.operand_1;
  assign out_operand_2 = id_ex_q.operand_2;
  assign out_imm       = id_ex_q.imm;
  assign out_dest      = id_ex_q.dest;
  assign out_reg_write = id_ex_q.reg_write;
  assign out_mem_read  = id_ex_q.mem_read;
  assign out_ctrl      = id_ex_q.ctrl;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed vectors, queue-based monitor.
// Build with OPERAND_STAGE_PERF_EN to also check the perf counters.
module tb_operand_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] imm;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic [15:0] ctrl;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_address_1;
  logic [4:0]  in_address_2;
  logic        in_use_1;
  logic        in_use_2;
  logic [4:0]  in_dest;
  logic        in_reg_write;
  logic        in_mem_read;
  logic [15:0] in_ctrl;
  logic [63:0] in_imm;
  logic [63:0] bank_data_1;
  logic [63:0] bank_data_2;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [63:0] ex_result;
  logic [4:0]  wb_dest;
  logic        wb_write;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_operand_1;
  logic [63:0] out_operand_2;
  logic [63:0] out_imm;
  logic [4:0]  out_dest;
  logic        out_reg_write;
  logic        out_mem_read;
  logic [15:0] out_ctrl;
`ifdef OPERAND_STAGE_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] forward_count;
`endif

  int   passed = 0;
  int   total  = 0;
  int   exp_stall = 0;
  int   exp_fwd   = 0;
  exp_t sb[$];
  logic fresh = 1'b1;

  always #5 clock = ~clock;

  operand_stage dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_address_1  (in_address_1),
    .in_address_2  (in_address_2),
    .in_use_1      (in_use_1),
    .in_use_2      (in_use_2),
    .in_dest       (in_dest),
    .in_reg_write  (in_reg_write),
    .in_mem_read   (in_mem_read),
    .in_ctrl       (in_ctrl),
    .in_imm        (in_imm),
    .bank_data_1   (bank_data_1),
    .bank_data_2   (bank_data_2),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_result     (ex_result),
    .wb_dest       (wb_dest),
    .wb_write      (wb_write),
    .wb_data       (wb_data),
    .flush         (flush),
`ifdef OPERAND_STAGE_PERF_EN
    .stall_count   (stall_count),
    .forward_count (forward_count),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_operand_1 (out_operand_1),
    .out_operand_2 (out_operand_2),
    .out_imm       (out_imm),
    .out_dest      (out_dest),
    .out_reg_write (out_reg_write),
    .out_mem_read  (out_mem_read),
    .out_ctrl      (out_ctrl)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2,
                         input logic [63:0] b1,
                         input logic [63:0] b2);
    in_address_1 = a1;
    in_use_1     = u1;
    in_address_2 = a2;
    in_use_2     = u2;
    bank_data_1  = b1;
    bank_data_2  = b2;
  endtask

  task automatic set_ctl(input logic [4:0] d, input logic rw,
                         input logic mr, input logic [15:0] c,
                         input logic [63:0] imm);
    in_dest      = d;
    in_reg_write = rw;
    in_mem_read  = mr;
    in_ctrl      = c;
    in_imm       = imm;
  endtask

  task automatic set_ex(input logic [4:0] d, input logic we,
                        input logic ld, input logic [63:0] r);
    ex_dest      = d;
    ex_reg_write = we;
    ex_mem_read  = ld;
    ex_result    = r;
  endtask

  task automatic set_wb(input logic [4:0] d, input logic we,
                        input logic [63:0] r);
    wb_dest  = d;
    wb_write = we;
    wb_data  = r;
  endtask

  // Expected operands are hand-computed; other fields echo the drive.
  task automatic push(input logic [63:0] o1, input logic [63:0] o2);
    exp_t e;
    e.op1  = o1;
    e.op2  = o2;
    e.imm  = in_imm;
    e.dest = in_dest;
    e.rw   = in_reg_write;
    e.mr   = in_mem_read;
    e.ctrl = in_ctrl;
    sb.push_back(e);
  endtask

  // A new instruction appears when out_valid follows an empty or drained slot.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid && fresh) begin
      exp_t a;
      exp_t e;
      a = {out_operand_1, out_operand_2, out_imm, out_dest,
           out_reg_write, out_mem_read, out_ctrl};
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_out: got %h want none", a);
      end else begin
        e = sb.pop_front();
        if (a === e) passed++;
        else $display("FAIL out_bundle: got %h want %h", a, e);
      end
    end
    fresh = !out_valid || out_ready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    set_src(5'd0, 1'b0, 5'd0, 1'b0, 64'h0, 64'h0);
    set_ctl(5'd0, 1'b0, 1'b0, 16'h0, 64'h0);
    set_ex(5'd0, 1'b0, 1'b0, 64'h0);
    set_wb(5'd0, 1'b0, 64'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_operand_1", out_operand_1, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    cyc();
    reset_n = 1'b1;

    // EX forward beats stale bank data
    in_valid = 1'b1;
    set_src(5'd3, 1'b1, 5'd4, 1'b1, 64'h11, 64'h22);
    set_ex(5'd3, 1'b1, 1'b0, 64'hAA);
    set_ctl(5'd10, 1'b1, 1'b0, 16'h1234, 64'h100);
    push(64'hAA, 64'h22);
    exp_fwd += 1;
    @(negedge clock);
    chk("ex_fwd_in_ready", 64'(in_ready), 64'd1);
    cyc();

    // WB forward on src1, bank on src2
    set_ex(5'd0, 1'b0, 1'b0, 64'h0);
    set_src(5'd5, 1'b1, 5'd6, 1'b1, 64'h0, 64'h66);
    set_wb(5'd5, 1'b1, 64'h55);
    set_ctl(5'd11, 1'b1, 1'b0, 16'h0002, 64'hFFFF_FFFF_FFFF_FFF0);
    push(64'h55, 64'h66);
    exp_fwd += 1;
    cyc();

    // XZR reads zero even with buses targeting X31
    set_src(5'd31, 1'b1, 5'd31, 1'b1, 64'h77, 64'h88);
    set_ex(5'd31, 1'b1, 1'b0, 64'hBEEF);
    set_wb(5'd31, 1'b1, 64'hDEAD);
    set_ctl(5'd12, 1'b1, 1'b0, 16'h0003, 64'h0);
    push(64'h0, 64'h0);
    cyc();

    // EX has priority over WB; an unused source ignores matches
    set_src(5'd8, 1'b1, 5'd8, 1'b0, 64'h18, 64'h28);
    set_ex(5'd8, 1'b1, 1'b0, 64'hE8);
    set_wb(5'd8, 1'b1, 64'hB8);
    set_ctl(5'd31, 1'b1, 1'b0, 16'h0004, 64'h5);
    push(64'hE8, 64'h28);
    exp_fwd += 1;
    cyc();

    // LDUR X7; held dest X31 must not cause a hazard on src2=X31
    set_ex(5'd0, 1'b0, 1'b0, 64'h0);
    set_wb(5'd0, 1'b0, 64'h0);
    set_src(5'd2, 1'b1, 5'd31, 1'b1, 64'h1000, 64'hAB);
    set_ctl(5'd7, 1'b1, 1'b1, 16'h0005, 64'h8);
    push(64'h1000, 64'h0);
    cyc();

    // ADD reads X7 while the load is held: bubble
    set_src(5'd7, 1'b1, 5'd1, 1'b1, 64'h70, 64'h5);
    set_ctl(5'd13, 1'b1, 1'b0, 16'h0006, 64'h0);
    @(negedge clock);
    chk("ldu_held_in_ready", 64'(in_ready), 64'd0);
    exp_stall += 1;
    cyc();

    // load now in EX/MEM
    set_ex(5'd7, 1'b1, 1'b1, 64'h1008);
    @(negedge clock);
    chk("ldu_bubble_valid", 64'(out_valid), 64'd0);
    chk("ldu_ex_in_ready", 64'(in_ready), 64'd0);
    exp_stall += 1;
    cyc();

    // load now in MEM/WB
    set_ex(5'd0, 1'b0, 1'b0, 64'h0);
    set_wb(5'd7, 1'b1, 64'h77);
    push(64'h77, 64'h5);
    exp_fwd += 1;
    @(negedge clock);
    chk("ldu_wb_in_ready", 64'(in_ready), 64'd1);
    cyc();

    // backpressure
    set_wb(5'd0, 1'b0, 64'h0);
    set_src(5'd20, 1'b1, 5'd21, 1'b0, 64'hB1, 64'h0);
    set_ctl(5'd14, 1'b1, 1'b0, 16'h0007, 64'h9);
    push(64'hB1, 64'h0);
    cyc();
    out_ready = 1'b0;
    set_src(5'd21, 1'b1, 5'd22, 1'b1, 64'hC1, 64'hC2);
    set_ctl(5'd15, 1'b1, 1'b0, 16'h0008, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_operand_1", out_operand_1, 64'hB1);
      chk("bp_dest", 64'(out_dest), 64'd14);
      cyc();
    end

    // flush drops held and incoming instruction
    flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    cyc();
    @(negedge clock);
    chk("flush_dropped", 64'(out_valid), 64'd0);
    cyc();
    cyc();
    @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef OPERAND_STAGE_PERF_EN
    chk("stall_count", 64'(stall_count), 64'(exp_stall));
    chk("forward_count", 64'(forward_count), 64'(exp_fwd));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
